adc_capture_buffer: RTL and testbench

//   Upstream feeder for the UART transmit stage of the oscilloscope.
//   - Samples the 8-bit parallel ADC bus and waits for a rising-edge trigger (or a timeout).
//   - Stores one DEPTH-sample record in block RAM.
//   - Streams the record to the UART transmitter as a header byte followed by DEPTH data

---
 rtl/osc_pkg.sv | 15 +
 rtl/adc_capture_buffer_if.sv | 12 +
 rtl/sample_ram.sv | 27 ++
 rtl/adc_capture_buffer.sv | 164 ++++++++++++++++
 tb/tb_adc_capture_buffer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/osc_pkg.sv
// Shared types and constants for the oscilloscope capture/transmit path.
// The clock rate is also consumed by the UART baud-rate logic.
package osc_pkg;
   localparam int               ADC_W        = 8;
   localparam int               CLK_HZ       = 27_000_000;
   localparam logic [ADC_W-1:0] DEF_HDR_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      CAPTURE,
      HEADER,
      DUMP
   } state_t;
endpackage

// File: rtl/adc_capture_buffer_if.sv
// Byte link between the capture buffer and the UART transmitter:
// one-cycle active-low send strobe, data byte, and the transmitter busy flag.
interface adc_capture_buffer_if;
   import osc_pkg::*;

   logic [ADC_W-1:0] tx_data;
   logic             tx_send_n;
   logic             tx_busy;

   modport master (output tx_data, output tx_send_n, input tx_busy);
   modport slave  (input tx_data, input tx_send_n, output tx_busy);
endinterface

// File: rtl/sample_ram.sv
// Simple dual-port sample store: one write port, one read port with a
// registered output so it maps onto block RAM.
module sample_ram
   import osc_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [ADC_W-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [ADC_W-1:0]  o_rdata
);
   logic [ADC_W-1:0] r_mem [DEPTH];
   logic [ADC_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/adc_capture_buffer.sv
// Captures one triggered (or timed-out) ADC record into block RAM and streams it
// to the UART transmitter as a header byte followed by DEPTH sample bytes.
module adc_capture_buffer
   import osc_pkg::*;
#(
   parameter int               DEPTH        = 256,
   parameter int               DECIM        = 1,
   parameter int               TRIG_TIMEOUT = CLK_HZ,
   parameter logic [ADC_W-1:0] HDR_BYTE     = DEF_HDR_BYTE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADC_W-1:0]     adc_data,
   input  logic                 arm,
   input  logic [ADC_W-1:0]     trig_level,
   adc_capture_buffer_if.master tx,
   output logic                 capturing,
   output logic                 frame_done
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int TO_W   = $clog2(TRIG_TIMEOUT + 1);

   localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIM - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TRIG_TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

   state_t            r_state, w_state_next;
   logic [ADC_W-1:0]  r_s0, r_prev, r_tx_data, w_rd_q;
   logic [DEC_W-1:0]  r_dec;
   logic [TO_W-1:0]   r_to;
   logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
   logic              r_send_n, r_send_d, r_last_pend, r_frame_done;
   logic              w_tick, w_edge, w_force, w_perm;
   logic              w_we, w_strobe, w_last;

   assign w_tick  = (r_dec == DEC_LAST);
   assign w_edge  = (r_prev < trig_level) && (r_s0 >= trig_level);
   assign w_force = (r_to == TO_LAST);
   // Two-cycle strobe guard covers the transmitter's busy-rise latency.
   assign w_perm  = !tx.tx_busy && r_send_n && r_send_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_we         = 1'b0;
      w_strobe     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            if (arm) w_state_next = ARMED;
         end
         ARMED: begin
            // A trigger takes priority over arm dropping in the same cycle.
            if (w_tick && (w_edge || w_force)) begin
               w_we         = 1'b1;
               w_state_next = CAPTURE;
            end else if (!arm) begin
               w_state_next = IDLE;
            end
         end
         CAPTURE: begin
            if (w_tick) begin
               w_we = 1'b1;
               if (r_wr_addr == ADDR_LAST) w_state_next = HEADER;
            end
         end
         HEADER: begin
            if (w_perm) begin
               w_strobe     = 1'b1;
               w_state_next = DUMP;
            end
         end
         DUMP: begin
            if (w_perm) begin
               w_strobe = 1'b1;
               if (r_rd_addr == ADDR_LAST) begin
                  w_last       = 1'b1;
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s0         <= '0;
         r_prev       <= '0;
         r_dec        <= '0;
         r_to         <= '0;
         r_wr_addr    <= '0;
         r_rd_addr    <= '0;
         r_tx_data    <= '0;
         r_send_n     <= 1'b1;
         r_send_d     <= 1'b1;
         r_last_pend  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_s0         <= adc_data;
         r_send_n     <= !w_strobe;
         r_send_d     <= r_send_n;
         r_last_pend  <= w_last;
         r_frame_done <= r_last_pend;

         if ((r_state == IDLE && arm) || w_tick) begin
            r_dec <= '0;
         end else begin
            r_dec <= r_dec + DEC_W'(1);
         end

         // Idle preload of 0xFF stops an already-high input from triggering at once.
         if (r_state == IDLE) begin
            r_prev <= '1;
         end else if (r_state == ARMED && w_tick) begin
            r_prev <= r_s0;
         end

         if (r_state != ARMED) begin
            r_to <= '0;
         end else if (!w_force) begin
            r_to <= r_to + TO_W'(1);
         end

         if (r_state == IDLE) begin
            r_wr_addr <= '0;
         end else if (w_we) begin
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
         end

         // The RAM reads r_rd_addr every cycle; it only moves on a strobe,
         // so the read has always settled before the next permitted strobe.
         if (w_strobe) begin
            r_tx_data <= (r_state == HEADER) ? HDR_BYTE : w_rd_q;
            if (r_state == DUMP) r_rd_addr <= r_rd_addr + ADDR_W'(1);
         end
      end
   end

   sample_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_addr),
      .i_wdata (r_s0),
      .i_raddr (r_rd_addr),
      .o_rdata (w_rd_q)
   );

   assign tx.tx_data   = r_tx_data;
   assign tx.tx_send_n = r_send_n;
   assign capturing    = (r_state == ARMED) || (r_state == CAPTURE);
   assign frame_done   = r_frame_done;
endmodule

// File: tb/tb_adc_capture_buffer.sv
// Scoreboard bench for adc_capture_buffer (DEPTH=16, DECIM=2, TRIG_TIMEOUT=101):
// stimulus queues expected bytes, a negedge monitor checks every strobe and frame_done.
module tb_adc_capture_buffer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] adc_data = 8'h00;
   logic [7:0] adc_step = 8'h00;
   logic       arm = 1'b0;
   logic [7:0] trig_level = 8'h80;
   logic       capturing;
   logic       frame_done;

   int   exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_strobe = 0;
   int   n_done = 0;
   int   busy_cnt = 0;
   bit   busy_pend = 1'b0;
   logic [7:0] last_tx = 8'h00;

   adc_capture_buffer_if txif();

   adc_capture_buffer #(
      .DEPTH        (16),
      .DECIM        (2),
      .TRIG_TIMEOUT (101),
      .HDR_BYTE     (8'hA5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .adc_data   (adc_data),
      .arm        (arm),
      .trig_level (trig_level),
      .tx         (txif),
      .capturing  (capturing),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Transmitter model: busy for 10 cycles, starting one cycle after each strobe.
   always begin
      @(posedge clk);
      #1;
      if (busy_pend) busy_cnt = 10;
      else if (busy_cnt > 0) busy_cnt--;
      busy_pend = (txif.tx_send_n == 1'b0);
      txif.tx_busy = (busy_cnt > 0);
   end

   // Monitor: every strobe pops one expected byte, every frame_done pops a -1 marker.
   always @(negedge clk) begin
      if (rst) begin
         last_tx = 8'h00;
      end else begin
         if (txif.tx_send_n == 1'b0) begin
            n_strobe++;
            check("strobe_while_busy", int'(txif.tx_busy), 0);
            check("strobe_expected", int'(exp_q.size() > 0 && exp_q[0] >= 0), 1);
            if (exp_q.size() > 0 && exp_q[0] >= 0)
               check("tx_byte", int'(txif.tx_data), exp_q.pop_front());
            last_tx = txif.tx_data;
         end else if (txif.tx_data !== last_tx) begin
            check("tx_data_hold", int'(txif.tx_data), int'(last_tx));
         end
         if (frame_done) begin
            n_done++;
            check("frame_done_expected", int'(exp_q.size() > 0 && exp_q[0] < 0), 1);
            if (exp_q.size() > 0 && exp_q[0] < 0) void'(exp_q.pop_front());
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         adc_data = adc_data + adc_step;
      end
   endtask

   task automatic push_frame(input int first, input int stride);
      exp_q.push_back(8'hA5);
      for (int k = 0; k < 16; k++) exp_q.push_back((first + stride * k) & 255);
      exp_q.push_back(-1);
   endtask

   task automatic wait_for(input string name, input bit on_done, input int target, input int budget);
      int b = 0;
      while (((on_done ? n_done : n_strobe) < target) && b < budget) begin
         cycles(1);
         b++;
      end
      check(name, int'((on_done ? n_done : n_strobe) >= target), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      cycles(3);
      rst = 1'b0;
      check("rst_send_n", int'(txif.tx_send_n), 1);
      check("rst_tx_data", int'(txif.tx_data), 0);
      check("rst_capturing", int'(capturing), 0);
      check("rst_frame_done", int'(frame_done), 0);
      cycles(2);

      // Rising ramp crosses 0x80 exactly on a tick; arm dropped mid-capture is ignored.
      push_frame(8'h80, 2);
      adc_data = 8'h71; adc_step = 8'h01; arm = 1'b1;
      cycles(3);
      check("t1_capturing_armed", int'(capturing), 1);
      cycles(17);
      check("t1_capturing_capture", int'(capturing), 1);
      arm = 1'b0;
      wait_for("t1_frame_done", 1'b1, 1, 600);
      check("t1_queue_empty", exp_q.size(), 0);
      check("t1_capturing_after", int'(capturing), 0);
      adc_step = 8'h00;
      cycles(5);

      // Ramp that stays above the level: only the timeout can trigger.
      push_frame(8'hF5, 2);
      adc_data = 8'h90; adc_step = 8'h01; arm = 1'b1;
      cycles(50);
      check("t2_still_armed", int'(capturing), 1);
      cycles(60);
      arm = 1'b0;
      wait_for("t2_frame_done", 1'b1, 2, 600);
      check("t2_queue_empty", exp_q.size(), 0);
      adc_step = 8'h00;
      cycles(5);

      // Arm withdrawn while ARMED: abort, no output.
      base = n_strobe;
      adc_data = 8'h10; arm = 1'b1;
      cycles(5);
      check("t3_capturing_armed", int'(capturing), 1);
      arm = 1'b0;
      cycles(2);
      check("t3_capturing_abort", int'(capturing), 0);
      cycles(150);
      check("t3_no_strobes", n_strobe, base);

      // Reset in the middle of the dump.
      push_frame(8'hC0, 0);
      base = n_strobe;
      adc_data = 8'hC0; arm = 1'b1;
      wait_for("t4_reach_byte8", 1'b0, base + 9, 800);
      rst = 1'b1; arm = 1'b0;
      exp_q.delete();
      cycles(1);
      rst = 1'b0;
      check("t4_send_n_after_rst", int'(txif.tx_send_n), 1);
      check("t4_capturing_after_rst", int'(capturing), 0);
      base = n_strobe;
      cycles(40);
      check("t4_quiet_after_rst", n_strobe, base);

      // Re-arm after reset; arm held so a second frame follows on its own.
      push_frame(8'hC0, 0);
      push_frame(8'hC0, 0);
      base = n_done;
      adc_data = 8'hC0; arm = 1'b1;
      wait_for("t5_frame1_done", 1'b1, base + 1, 800);
      wait_for("t5_frame2_header", 1'b0, n_strobe + 1, 800);
      arm = 1'b0;
      wait_for("t5_frame2_done", 1'b1, base + 2, 800);
      base = n_strobe;
      cycles(300);
      check("t5_no_third_frame", n_strobe, base);
      check("t5_queue_empty", exp_q.size(), 0);
      check("t5_capturing_end", int'(capturing), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
